// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed 4-digit display scanner. Holds a frame-
//               consistent display value, scans the digits with a blanking
//               gap between them, and drives the per-digit nibble plus
//               active-low anode and decimal-point strobes. New values are
//               staged in shadow registers and committed at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int ACTIVE_CYCLES = 100000,
    parameter int BLANK_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  digit_data,
    output logic [3:0]  anode,
    output logic        dp,
    output logic        frame_done,
    output logic        update_pending
);

    localparam int c_max_cycles = (ACTIVE_CYCLES > BLANK_CYCLES) ? ACTIVE_CYCLES : BLANK_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    localparam logic [c_cnt_w-1:0] c_act_last = c_cnt_w'(ACTIVE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blk_last = c_cnt_w'(BLANK_CYCLES - 1);

    localparam logic [0:0] c_st_active = 1'b0;
    localparam logic [0:0] c_st_blank  = 1'b1;

    // Scan state
    logic [0:0]         r_state;
    logic [1:0]         r_sel;
    logic [c_cnt_w-1:0] r_cnt;

    // Display and shadow registers
    logic [15:0] r_disp_data;
    logic [3:0]  r_disp_dp;
    logic [3:0]  r_disp_en;
    logic [15:0] r_sh_data;
    logic [3:0]  r_sh_dp;
    logic [3:0]  r_sh_en;
    logic        r_pending;

    // Registered outputs
    logic [3:0]  r_digit_data;
    logic [3:0]  r_anode;
    logic        r_dp;
    logic        r_frame_done;

    // Next-state values
    logic [0:0]         w_state_nxt;
    logic [1:0]         w_sel_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_commit;
    logic [15:0]        w_disp_data_nxt;
    logic [3:0]         w_disp_dp_nxt;
    logic [3:0]         w_disp_en_nxt;
    logic [15:0]        w_sh_data_nxt;
    logic [3:0]         w_sh_dp_nxt;
    logic [3:0]         w_sh_en_nxt;
    logic               w_pending_nxt;

    // Output values for the upcoming cycle
    logic [3:0]  w_digit_data_nxt;
    logic [3:0]  w_anode_nxt;
    logic        w_dp_nxt;
    logic        w_frame_done_nxt;
    logic        w_lit_nxt;

    // State register: scan counters, display/shadow registers and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_active;
            r_sel        <= 2'd0;
            r_cnt        <= '0;
            r_disp_data  <= 16'h0000;
            r_disp_dp    <= 4'h0;
            r_disp_en    <= 4'h0;
            r_sh_data    <= 16'h0000;
            r_sh_dp      <= 4'h0;
            r_sh_en      <= 4'h0;
            r_pending    <= 1'b0;
            r_digit_data <= 4'h0;
            r_anode      <= 4'hF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp_data  <= w_disp_data_nxt;
            r_disp_dp    <= w_disp_dp_nxt;
            r_disp_en    <= w_disp_en_nxt;
            r_sh_data    <= w_sh_data_nxt;
            r_sh_dp      <= w_sh_dp_nxt;
            r_sh_en      <= w_sh_en_nxt;
            r_pending    <= w_pending_nxt;
            r_digit_data <= w_digit_data_nxt;
            r_anode      <= w_anode_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Next-state: ACTIVE/BLANK timing, digit advance, commit and load handling
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_commit    = 1'b0;
        case (r_state)
            c_st_active: begin
                if (r_cnt == c_act_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_blank;
                end
            end
            default: begin
                if (r_cnt == c_blk_last) begin
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = r_sel + 2'd1;
                    w_state_nxt = c_st_active;
                    w_commit    = (r_sel == 2'd3);
                end
            end
        endcase

        // Commit takes the shadow as it stood before this edge; a load on the
        // same edge therefore stays pending for the following frame.
        w_disp_data_nxt = r_disp_data;
        w_disp_dp_nxt   = r_disp_dp;
        w_disp_en_nxt   = r_disp_en;
        w_pending_nxt   = r_pending;
        if (w_commit && r_pending) begin
            w_disp_data_nxt = r_sh_data;
            w_disp_dp_nxt   = r_sh_dp;
            w_disp_en_nxt   = r_sh_en;
            w_pending_nxt   = 1'b0;
        end

        w_sh_data_nxt = r_sh_data;
        w_sh_dp_nxt   = r_sh_dp;
        w_sh_en_nxt   = r_sh_en;
        if (load) begin
            w_sh_data_nxt = data_in;
            w_sh_dp_nxt   = dp_in;
            w_sh_en_nxt   = digit_en;
            w_pending_nxt = 1'b1;
        end
    end

    // Output decode from next-state so each registered output matches its cycle
    always_comb begin
        w_lit_nxt        = (w_state_nxt == c_st_active) && w_disp_en_nxt[w_sel_nxt];
        w_anode_nxt      = w_lit_nxt ? ~(4'b0001 << w_sel_nxt) : 4'hF;
        w_digit_data_nxt = w_disp_data_nxt[{w_sel_nxt, 2'b00} +: 4];
        w_dp_nxt         = 1'b1;
        if (w_state_nxt == c_st_active) begin
            w_dp_nxt = ~(w_disp_dp_nxt[w_sel_nxt] & w_disp_en_nxt[w_sel_nxt]);
        end
        // The last BLANK cycle of digit 3 is the one ending on the commit edge
        w_frame_done_nxt = (w_state_nxt == c_st_blank) && (w_sel_nxt == 2'd3) &&
                           (w_cnt_nxt == c_blk_last);
    end

    assign digit_data     = r_digit_data;
    assign anode          = r_anode;
    assign dp             = r_dp;
    assign frame_done     = r_frame_done;
    assign update_pending = r_pending;

endmodule
`default_nettype wire

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed 4-digit display scanner that sits directly upstream of the hex-to-segment decoder. It holds a frame-consistent 16-bit display value, cycles through the digits one at a time, and drives the per-digit nibble to the decoder together with active-low anode and decimal-point strobes. A blanking gap between digits prevents ghosting. New values are accepted on a load pulse and applied only at a frame boundary, so a digit never shows a half-updated value.

## Interface
- ACTIVE_CYCLES, 100000: clock cycles each digit is lit (1 ms at 100 MHz); must be ≥ 1.
- BLANK_CYCLES, 1000: clock cycles all anodes are off between digits; must be ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; captures data_in, dp_in and digit_en into the pending (shadow) registers.
- data_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  decimal point request per digit, active-high; bit i is digit i.
- digit_en  input  4  digit enable per digit; a disabled digit keeps its time slot but its anode stays off.
- digit_data  output  4  nibble of the currently selected digit; feeds the decoder's data input.
- anode  output  4  active-low digit select; at most one bit is low at any time.
- dp  output  1  active-low decimal point for the currently lit digit.
- frame_done  output  1  one-cycle pulse at each frame boundary (the commit edge).
- update_pending  output  1  high while a loaded value is waiting for commit.

## Operation
- Registers:
  - Display registers disp_data[15:0], disp_dp[3:0] and disp_en[3:0].
  - Shadow registers with a pending flag.
  - 2-bit digit select sel.
  - Cycle counter cnt, sized as clog2 of max(ACTIVE_CYCLES, BLANK_CYCLES).
  - State register with states ACTIVE and BLANK.
- ACTIVE: cnt counts 0..ACTIVE_CYCLES-1. When cnt reaches ACTIVE_CYCLES-1, cnt clears and the state goes to BLANK.
- BLANK: cnt counts 0..BLANK_CYCLES-1. When cnt reaches BLANK_CYCLES-1:
  - cnt clears, sel increments (3 wraps to 0), and the state goes to ACTIVE.
- Frame boundary: the BLANK→ACTIVE edge on which sel wraps from 3 to 0. On that edge:
  - frame_done pulses high for exactly one cycle.
  - If pending = 1, the shadow registers copy into the display registers and pending clears.
- Load:
  - load = 1 writes the shadow registers and sets pending.
  - Repeated loads before a commit overwrite the shadow; the last load wins.
- Load on the commit edge: the previous shadow contents are committed. The newly loaded value stays pending for the next frame, and update_pending remains 1.
- Outputs are registered; each reflects the state and sel in force during that cycle:
  - anode: when the state is ACTIVE and disp_en[sel] = 1, anode = ~(4'b0001 << sel); otherwise anode = 4'hF.
  - digit_data = disp_data[4*sel +: 4], driven in both states.
  - dp = ~(disp_dp[sel] & disp_en[sel]) while ACTIVE; dp = 1 while BLANK.
- Reset (asynchronous assert, any time, including mid-frame):
  - State is ACTIVE, sel = 0, cnt = 0.
  - All display and shadow registers are 0; pending = 0.
  - anode = 4'hF, dp = 1, digit_data = 4'h0, frame_done = 0, update_pending = 0.
  - The display is therefore dark until the first committed load enables digits.

## Timing
- Digit period: ACTIVE_CYCLES + BLANK_CYCLES.
- Frame period: 4 × (ACTIVE_CYCLES + BLANK_CYCLES).
- After reset release, digit 0 is ACTIVE for cycles 0..ACTIVE_CYCLES-1. The first frame_done occurs at cycle 4 × (ACTIVE_CYCLES + BLANK_CYCLES) - 1.
- Load-to-display latency: from 1 cycle (load on the edge just before commit) up to one frame plus 1 cycle.
- update_pending rises the cycle after load and falls the cycle after the commit edge.
- anode never has two bits low, even transiently. Every sel change occurs during BLANK.

## Test plan
Benches use ACTIVE_CYCLES = 4 and BLANK_CYCLES = 2, giving a 24-cycle frame.
- Reset then idle: for 48 cycles, anode = 4'hF, dp = 1, update_pending = 0; frame_done pulses at cycles 23 and 47.
- Basic load: load with data_in = 16'h1A3F, digit_en = 4'hF, dp_in = 4'b0100 at cycle 2.
  - update_pending is high from cycle 3 through cycle 23.
  - Next frame: digit 0 lit with anode = 4'b1110 and digit_data = F for 4 cycles, then 2 cycles of 4'hF.
  - Then digit 1 = 3, digit 2 = A with dp = 0, digit 3 = 1.
- Tear-free update: load 16'h1234, then load 16'hABCD mid-frame. The display shows 1234 for the rest of the frame, and ABCD only from the next frame boundary.
- Collision: load 16'h5555 on the same edge as a commit of 16'h9999. The next frame shows 9999, update_pending stays 1, and the following frame shows 5555.
- Disabled digits: digit_en = 4'b0101. anode only ever takes values 4'hF, 4'b1110 and 4'b1011; the frame period stays 24 cycles.
- Reset mid-frame: assert rst_n low during digit 2 ACTIVE. anode = 4'hF immediately (asynchronously) and the display stays dark after release until a new load commits.
